// File: rtl/pipeline_enable_ctrl_if.sv
// Control/strobe bundle between the debug unit and the pipeline enable controller.
// Handshake: the command inputs are single-cycle level pulses sampled on the rising
// clk edge; there is no valid/ready back-pressure. The controller simply takes a
// command when its current state accepts it and ignores it otherwise.
interface pipeline_enable_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_start_run;
  logic             i_start_step;
  logic             i_step;
  logic             i_clear;
  logic             i_hazard_stall;
  logic             i_halt_detect;
  logic             o_pc_enable;
  logic             o_ifid_enable;
  logic             o_pipe_enable;
  logic             o_halted;
  logic             o_busy;
  logic [CNT_W-1:0] o_cycle_count;
  logic [2:0]       o_state_dbg;
  logic             o_step_mode_dbg;

  // Command source (debug unit / hazard logic side)
  modport master (
    output i_start_run, i_start_step, i_step, i_clear, i_hazard_stall, i_halt_detect,
    input  o_pc_enable, o_ifid_enable, o_pipe_enable, o_halted, o_busy, o_cycle_count,
    input  o_state_dbg, o_step_mode_dbg
  );

  // Enable controller side
  modport slave (
    input  i_start_run, i_start_step, i_step, i_clear, i_hazard_stall, i_halt_detect,
    output o_pc_enable, o_ifid_enable, o_pipe_enable, o_halted, o_busy, o_cycle_count,
    output o_state_dbg, o_step_mode_dbg
  );
endinterface

// File: rtl/pipeline_enable_ctrl.sv
// Generates the pipeline register enables: continuous run, single-step,
// load-use fetch freeze, HALT drain, and an enabled-cycle counter.
module pipeline_enable_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_enable_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             halt_seen_q, halt_seen_d;
  logic             step_mode_q, step_mode_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enabled;

  // The pipeline advances only in these three states.
  assign enabled = (state_q == S_RUN) || (state_q == S_STEP_EXEC) || (state_q == S_DRAIN);

  // State and counters; reset is asynchronous so enables drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      halt_seen_q <= 1'b0;
      step_mode_q <= 1'b0;
      drain_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      step_mode_q <= step_mode_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; clear is applied last so it overrides everything.
  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    step_mode_d = step_mode_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;

    if (enabled && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_start_run) begin
          state_d = S_RUN;
        end else if (bus.i_start_step) begin
          state_d     = S_STEP_WAIT;
          step_mode_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.i_halt_detect) begin
          halt_seen_d = 1'b1;
          drain_d     = DW'(DRAIN_CYCLES);
          state_d     = S_DRAIN;
        end
      end
      S_STEP_WAIT: begin
        if (bus.i_step) begin
          state_d = S_STEP_EXEC;
        end
      end
      S_STEP_EXEC: begin
        // Once a HALT is in flight each step retires one drain slot;
        // a later HALT opcode does not reload the count.
        if (halt_seen_q) begin
          if (drain_q <= DW'(1)) begin
            drain_d = '0;
            state_d = S_HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
            state_d = S_STEP_WAIT;
          end
        end else if (bus.i_halt_detect) begin
          halt_seen_d = 1'b1;
          drain_d     = DW'(DRAIN_CYCLES);
          state_d     = S_STEP_WAIT;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      S_DRAIN: begin
        if (drain_q <= DW'(1)) begin
          drain_d = '0;
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.i_clear) begin
      state_d     = S_IDLE;
      halt_seen_d = 1'b0;
      step_mode_d = 1'b0;
      drain_d     = '0;
      cnt_d       = '0;
    end
  end

  // Fetch is frozen by a pending drain, a load-use stall, or a HALT in IF/ID.
  assign bus.o_pc_enable     = enabled & ~halt_seen_q & ~bus.i_hazard_stall & ~bus.i_halt_detect;
  assign bus.o_ifid_enable   = enabled & ~halt_seen_q & ~bus.i_hazard_stall & ~bus.i_halt_detect;
  assign bus.o_pipe_enable   = enabled;
  assign bus.o_halted        = (state_q == S_HALTED);
  assign bus.o_busy          = (state_q == S_RUN) || (state_q == S_STEP_WAIT) ||
                               (state_q == S_STEP_EXEC) || (state_q == S_DRAIN);
  assign bus.o_cycle_count   = cnt_q;
  assign bus.o_state_dbg     = state_q;
  assign bus.o_step_mode_dbg = step_mode_q;

endmodule

// File: tb/tb_pipeline_enable_ctrl.sv
// Bench for pipeline_enable_ctrl: directed test-plan sequences followed by
// random command traffic, all compared against a behavioural model.
module tb_pipeline_enable_ctrl;

  localparam int D   = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_enable_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_enable_ctrl #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Described by activity rather than state codes: is the pipeline advancing
  // continuously, waiting for a step, executing a step, or halted; m_left is
  // how many enabled cycles (run) or steps (step mode) remain after a HALT,
  // -1 when no HALT is in flight.
  bit m_active, m_armed, m_exec, m_halted;
  int m_left, m_cnt;

  task automatic model_reset();
    m_active = 0; m_armed = 0; m_exec = 0; m_halted = 0;
    m_left = -1; m_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, checks outputs mid-cycle, advances the model.
  task automatic cyc(input bit sr, input bit ss, input bit st, input bit cl,
                     input bit hz, input bit hd);
    bit en, fetch, busy, idle;
    bus.i_start_run    = sr;
    bus.i_start_step   = ss;
    bus.i_step         = st;
    bus.i_clear        = cl;
    bus.i_hazard_stall = hz;
    bus.i_halt_detect  = hd;
    @(negedge clk);
    en    = m_active || m_exec;
    fetch = en && (m_left < 0) && !hz && !hd;
    busy  = m_active || m_armed || m_exec;
    check_eq("pipe_en", 32'(bus.o_pipe_enable), 32'(en));
    check_eq("pc_en",   32'(bus.o_pc_enable),   32'(fetch));
    check_eq("ifid_en", 32'(bus.o_ifid_enable), 32'(fetch));
    check_eq("halted",  32'(bus.o_halted),      32'(m_halted));
    check_eq("busy",    32'(bus.o_busy),        32'(busy));
    check_eq("count",   32'(bus.o_cycle_count), 32'(m_cnt));
    if (cl) begin
      model_reset();
    end else begin
      idle = !(busy || m_halted);
      if (en && m_cnt < SAT) m_cnt++;
      if (idle) begin
        if (sr) m_active = 1;
        else if (ss) m_armed = 1;
      end else if (m_active) begin
        if (m_left < 0) begin
          if (hd) m_left = D;
        end else begin
          m_left--;
          if (m_left == 0) begin m_active = 0; m_halted = 1; end
        end
      end else if (m_armed) begin
        if (st) begin m_armed = 0; m_exec = 1; end
      end else if (m_exec) begin
        m_exec = 0;
        if (m_left >= 0) begin
          m_left--;
          if (m_left <= 0) m_halted = 1; else m_armed = 1;
        end else begin
          if (hd) m_left = D;
          m_armed = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.i_start_run = 0; bus.i_start_step = 0; bus.i_step = 0;
    bus.i_clear = 0; bus.i_hazard_stall = 0; bus.i_halt_detect = 0;
    model_reset();
    #12;
    check_eq("rst_pipe",   32'(bus.o_pipe_enable), 0);
    check_eq("rst_pc",     32'(bus.o_pc_enable),   0);
    check_eq("rst_halted", 32'(bus.o_halted),      0);
    check_eq("rst_busy",   32'(bus.o_busy),        0);
    check_eq("rst_count",  32'(bus.o_cycle_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Run mode: start, stall two cycles, HALT, drain to HALTED.
    idle_n(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(3);
    check_eq("run_cnt3", 32'(bus.o_cycle_count), 3);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle_n(1);
    cyc(0, 0, 0, 0, 0, 1);
    idle_n(6);
    check_eq("halt_flag", 32'(bus.o_halted), 1);
    check_eq("halt_cnt",  32'(bus.o_cycle_count), 3 + 2 + 1 + 1 + D);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("halt_hold", 32'(bus.o_halted), 1);
    cyc(0, 0, 0, 1, 0, 0);
    check_eq("clr_cnt", 32'(bus.o_cycle_count), 0);

    // Step mode: three spaced steps, then a step while idle.
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0, 0);
      idle_n(2);
    end
    check_eq("step_cnt3", 32'(bus.o_cycle_count), 3);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check_eq("idle_step", 32'(bus.o_busy), 0);

    // Step mode with HALT on the 2nd step, halted after the 6th.
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, (k == 2));
      idle_n(1);
    end
    check_eq("stephalt",     32'(bus.o_halted), 1);
    check_eq("stephalt_cnt", 32'(bus.o_cycle_count), 6);
    cyc(0, 0, 0, 1, 0, 0);

    // HALT together with a stall, then clear in the middle of the drain.
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(2);
    cyc(0, 0, 0, 0, 1, 1);
    idle_n(2);
    cyc(0, 0, 0, 1, 0, 0);
    check_eq("drain_clr", 32'(bus.o_busy), 0);

    // Saturation, then clear coincident with start_run.
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(20);
    check_eq("sat_cnt", 32'(bus.o_cycle_count), SAT);
    cyc(1, 0, 0, 1, 0, 0);
    check_eq("clr_start_busy", 32'(bus.o_busy), 0);
    check_eq("clr_start_cnt",  32'(bus.o_cycle_count), 0);
    idle_n(2);

    // Asynchronous reset in the middle of a run.
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_pipe",  32'(bus.o_pipe_enable), 0);
    check_eq("arst_pc",    32'(bus.o_pc_enable),   0);
    check_eq("arst_busy",  32'(bus.o_busy),        0);
    check_eq("arst_count", 32'(bus.o_cycle_count), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Random command traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
